// File: rtl/line_fill_engine_pkg.sv
// line_fill_engine_pkg: shared types and constants for the line refill/writeback engine.
package line_fill_engine_pkg;
    localparam int ADDR_W         = 12;
    localparam int LINE_W         = 256;
    localparam int WORDS_PER_LINE = 4;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [7:0] WSTRB_ALL = 8'hFF;
    typedef enum logic [2:0] {IDLE, WB, RD, RDW, RESP} state_e;
endpackage

// File: rtl/line_fill_engine.sv
// line_fill_engine: writes back a dirty victim line, then refills one line from RAM
// and hands it to the data cache.
module line_fill_engine
    import line_fill_engine_pkg::*;
#(
    parameter int ADDR_W = line_fill_engine_pkg::ADDR_W,
    parameter int LINE_W = line_fill_engine_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_wb_addr,
    input  logic [LINE_W-1:0] req_wb_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [LINE_W-1:0] resp_data,
    output logic [ADDR_W-1:0] ram_axi_awaddr,
    output logic              ram_axi_awvalid,
    input  logic              ram_axi_awready,
    output logic [LINE_W-1:0] ram_axi_wdata,
    output logic [7:0]        ram_axi_wstrb,
    output logic              ram_axi_wvalid,
    input  logic              ram_axi_wready,
    output logic [ADDR_W-1:0] ram_axi_araddr,
    output logic              ram_axi_arvalid,
    input  logic              ram_axi_arready,
    input  logic [LINE_W-1:0] ram_axi_rdata,
    input  logic              ram_axi_rvalid,
    output logic              ram_axi_rready
);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [LINE_W-1:0] wdata_q, line_q;

    assign req_ready       = state_q == IDLE;
    assign ram_axi_awvalid = state_q == WB;
    assign ram_axi_wvalid  = state_q == WB;
    assign ram_axi_arvalid = state_q == RD;
    assign ram_axi_rready  = state_q == RDW;
    assign resp_valid      = state_q == RESP;
    assign ram_axi_awaddr  = awaddr_q;
    assign ram_axi_wdata   = wdata_q;
    assign ram_axi_araddr  = araddr_q;
    assign ram_axi_wstrb   = WSTRB_ALL;
    assign resp_data       = line_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = req_valid ? (req_wb ? WB : RD) : IDLE;
            WB:      state_d = (ram_axi_awready && ram_axi_wvalid) ? RD : WB;
            RD:      state_d = ram_axi_arready ? RDW : RD;
            RDW:     state_d = ram_axi_rvalid ? RESP : RDW;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
        end else begin
            state_q <= state_d;
            if (req_valid && req_ready) begin
                araddr_q <= req_addr & ADDR_MASK;
                if (req_wb) begin
                    awaddr_q <= req_wb_addr & ADDR_MASK;
                    wdata_q  <= req_wb_data;
                end
            end
            // rdata is only valid while the read address is being accepted
            if (state_q == RD && ram_axi_arready) line_q <= ram_axi_rdata;
        end
    end
endmodule

// File: tb/tb_line_fill_engine.sv
// tb_line_fill_engine: directed checks of the line fill engine against a word-addressed RAM model.
module tb_line_fill_engine;
    logic         clk = 0, rst = 1;
    logic         req_valid = 0, req_ready, req_wb = 0;
    logic [11:0]  req_addr = 0, req_wb_addr = 0;
    logic [255:0] req_wb_data = 0;
    logic         resp_valid, resp_ready = 0;
    logic [255:0] resp_data;
    logic [11:0]  awaddr, araddr;
    logic         awvalid, awready = 1, wvalid, wready = 1;
    logic [255:0] wdata, rdata;
    logic [7:0]   wstrb;
    logic         arvalid, arready = 1, rvalid = 1, rready;
    logic [63:0]  mem [0:4095];
    int           n_chk = 0, n_fail = 0, lat;

    localparam logic [255:0] PAT_A = 256'hA3A3_0003_0000_0003_A2A2_0002_0000_0002_A1A1_0001_0000_0001_A0A0_0000_0000_0000;
    localparam logic [255:0] PAT_B = 256'hB3B3_1111_2222_3333_B2B2_4444_5555_6666_B1B1_7777_8888_9999_B0B0_AAAA_BBBB_CCCC;

    line_fill_engine dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .ram_axi_awaddr(awaddr), .ram_axi_awvalid(awvalid), .ram_axi_awready(awready),
        .ram_axi_wdata(wdata), .ram_axi_wstrb(wstrb), .ram_axi_wvalid(wvalid), .ram_axi_wready(wready),
        .ram_axi_araddr(araddr), .ram_axi_arvalid(arvalid), .ram_axi_arready(arready),
        .ram_axi_rdata(rdata), .ram_axi_rvalid(rvalid), .ram_axi_rready(rready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [11:0] i);
        return {16'hC0DE, 4'h0, i, 32'h5A5A_5A5A ^ {20'h0, i}};
    endfunction

    function automatic logic [255:0] line_exp(input logic [11:0] a);
        return {pat(a + 12'd3), pat(a + 12'd2), pat(a + 12'd1), pat(a)};
    endfunction

    function automatic logic [255:0] line_at(input logic [11:0] a);
        return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
    endfunction

    // data is driven only during the read-address handshake; anything else is junk
    assign rdata = (arvalid && arready) ? line_at(araddr) : {256{1'b1}};

    always @(posedge clk)
        if (awvalid && awready && wvalid && wready)
            for (int i = 0; i < 4; i++) mem[awaddr + 12'(i)] <= wdata[64*i +: 64];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [11:0] a, input logic wb, input logic [11:0] wa, input logic [255:0] wd);
        @(negedge clk);
        req_valid = 1; req_addr = a; req_wb = wb; req_wb_addr = wa; req_wb_data = wd;
        chk("req_ready_before_accept", 256'(req_ready), 256'(1));
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
    endtask

    task automatic wait_resp();
        while (!resp_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_resp();
        @(negedge clk);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        chk("resp_valid_after_hs", 256'(resp_valid), 256'(0));
        chk("req_ready_after_hs", 256'(req_ready), 256'(1));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
        #2 rst = 0;
        #1;
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_valids", {251'(0), resp_valid, awvalid, wvalid, arvalid, rready}, 256'(0));
        chk("rst_wstrb", 256'(wstrb), 256'hFF);
        chk("rst_resp_data", resp_data, 256'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;

        // clean miss
        send(12'h010, 0, 12'h000, 256'(0));
        chk("clean_arvalid", 256'(arvalid), 256'(1));
        chk("clean_araddr", 256'(araddr), 256'h010);
        wait_resp();
        chk("clean_latency", 256'(lat), 256'(3));
        chk("clean_data", resp_data, line_exp(12'h010));
        finish_resp();

        // dirty miss, victim address misaligned on purpose
        send(12'h040, 1, 12'h021, PAT_A);
        chk("dirty_aw_w_valid", {254'(0), awvalid, wvalid}, 256'b11);
        chk("dirty_arvalid_low", 256'(arvalid), 256'(0));
        chk("dirty_awaddr", 256'(awaddr), 256'h020);
        chk("dirty_wdata", wdata, PAT_A);
        chk("dirty_wstrb", 256'(wstrb), 256'hFF);
        wait_resp();
        chk("dirty_latency", 256'(lat), 256'(4));
        chk("dirty_data", resp_data, line_exp(12'h040));
        chk("dirty_ram_line", line_at(12'h020), PAT_A);
        finish_resp();

        // writeback then refill of the same line, with write channel stalled two cycles
        awready = 0; wready = 0;
        send(12'h080, 1, 12'h080, PAT_B);
        repeat (2) begin
            @(posedge clk); #1;
            lat++;
            chk("wb_stall_awvalid", {254'(0), awvalid, wvalid}, 256'b11);
        end
        @(negedge clk);
        awready = 1; wready = 1;
        wait_resp();
        chk("same_line_latency", 256'(lat), 256'(6));
        chk("same_line_data", resp_data, PAT_B);
        finish_resp();

        // misaligned refill address
        send(12'h013, 0, 12'h000, 256'(0));
        chk("misaligned_araddr", 256'(araddr), 256'h010);
        wait_resp();
        chk("misaligned_data", resp_data, line_exp(12'h010));
        finish_resp();

        // response backpressure with a competing request
        send(12'h040, 0, 12'h000, 256'(0));
        wait_resp();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1; req_addr = 12'h100;
            @(posedge clk); #1;
            chk("bp_resp_valid", 256'(resp_valid), 256'(1));
            chk("bp_resp_data", resp_data, line_exp(12'h040));
            chk("bp_req_ready", 256'(req_ready), 256'(0));
        end
        @(negedge clk) req_valid = 0;
        finish_resp();

        // asynchronous reset while waiting in RDW
        rvalid = 0;
        send(12'h010, 0, 12'h000, 256'(0));
        @(posedge clk); #1;
        chk("rdw_rready", 256'(rready), 256'(1));
        #2 rst = 0;
        #1;
        chk("arst_req_ready", 256'(req_ready), 256'(1));
        chk("arst_valids", {251'(0), resp_valid, awvalid, wvalid, arvalid, rready}, 256'(0));
        chk("arst_addrs", {232'(0), awaddr, araddr}, 256'(0));
        chk("arst_wdata", wdata, 256'(0));
        chk("arst_resp_data", resp_data, 256'(0));
        @(negedge clk);
        rst = 1; rvalid = 1;
        send(12'h010, 0, 12'h000, 256'(0));
        wait_resp();
        chk("post_rst_latency", 256'(lat), 256'(3));
        chk("post_rst_data", resp_data, line_exp(12'h010));
        finish_resp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
